// File: rtl/dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dram_port_arbiter
//
// Shares one single-port data DRAM among N_REQ cores. Arbitration is
// round-robin. A grant is held while its core keeps i_req high. After
// MAX_BURST consecutive beats the grant moves on if any other core is waiting.
// The granted core's address, write enable and write data are muxed
// combinationally onto the DRAM port. Read data comes back to the owning core
// one cycle after the read beat.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req   [N]      per-core request level
//   i_wr    [N]      per-core beat type (1 = write, 0 = read)
//   i_addr  [N*A]    per-core address, core k at [k*ADDR_W +: ADDR_W]
//   i_wdata [N*D]    per-core write data, same slicing
//   o_gnt   [N]      one-hot grant (registered)
//   o_rvalid[N]      one-cycle read-data-valid pulse for the owning core
//   o_rdata [D]      shared read data, qualified by o_rvalid
//   o_dram_en/wr/addr/wdata   DRAM command port
//   i_dram_rdata     DRAM read data, valid the cycle after a read strobe
//   o_busy           high while any grant is held
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dram_port_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_wr,
  input  logic [N_REQ*ADDR_W-1:0]   i_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_wdata,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [N_REQ-1:0]          o_rvalid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_dram_en,
  output logic                      o_dram_wr,
  output logic [ADDR_W-1:0]         o_dram_addr,
  output logic [DATA_W-1:0]         o_dram_wdata,
  input  logic [DATA_W-1:0]         i_dram_rdata,
  output logic                      o_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [N_REQ-1:0] GNT_ONE  = N_REQ'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Round-robin pick: first set bit of req scanning from ptr+1 upward with
  // wrap-around. Returns {found, index}. ptr itself is examined last, so a
  // caller that must skip the current owner masks it out of req.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int             c;
    res = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      c = (int'(ptr) + i) % N_REQ;
      if (!res[IDX_W] && req[c]) begin
        res = {1'b1, IDX_W'(c)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t              state_r;
  logic [N_REQ-1:0]    gnt_r;
  logic [N_REQ-1:0]    rvalid_r;
  logic [IDX_W-1:0]    ptr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   rdata_hold_r;
  logic                busy_r;

  logic [IDX_W-1:0]    owner_s;
  logic                beat_s;
  logic                own_wr_s;
  logic [ADDR_W-1:0]   own_addr_s;
  logic [DATA_W-1:0]   own_wdata_s;
  logic [IDX_W:0]      pick_any_s;
  logic [IDX_W:0]      pick_other_s;

  // One-hot grant to owner index.
  always_comb begin
    owner_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_r[k]) begin
        owner_s = IDX_W'(k);
      end else begin
        owner_s = owner_s;
      end
    end
  end

  // Owner's command slices, beat detection and the two arbitration candidates.
  always_comb begin
    beat_s       = |(gnt_r & i_req);
    own_wr_s     = i_wr[owner_s];
    own_addr_s   = i_addr[int'(owner_s)*ADDR_W +: ADDR_W];
    own_wdata_s  = i_wdata[int'(owner_s)*DATA_W +: DATA_W];
    pick_any_s   = rr_pick(i_req, ptr_r);
    pick_other_s = rr_pick(i_req & ~gnt_r, ptr_r);
  end

  // DRAM command port; address and data are forced to zero with no grant so
  // idle cores' buses never leak onto the DRAM.
  always_comb begin
    o_dram_en = beat_s;
    o_dram_wr = beat_s & own_wr_s;
    if (|gnt_r) begin
      o_dram_addr  = own_addr_s;
      o_dram_wdata = own_wdata_s;
    end else begin
      o_dram_addr  = '0;
      o_dram_wdata = '0;
    end
  end

  // Arbitration FSM: grant, round-robin pointer and burst counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      gnt_r   <= '0;
      ptr_r   <= IDX_W'(N_REQ - 1);
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s[IDX_W]) begin
            state_r <= ST_GRANT;
            gnt_r   <= GNT_ONE << pick_any_s[IDX_W-1:0];
            ptr_r   <= pick_any_s[IDX_W-1:0];
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (!beat_s) begin
            // Owner released: hand over directly, or fall back to idle.
            if (pick_any_s[IDX_W]) begin
              gnt_r <= GNT_ONE << pick_any_s[IDX_W-1:0];
              ptr_r <= pick_any_s[IDX_W-1:0];
              cnt_r <= '0;
            end else begin
              state_r <= ST_IDLE;
              gnt_r   <= '0;
              cnt_r   <= '0;
              busy_r  <= 1'b0;
            end
          end else if (cnt_r == CNT_LAST) begin
            // Burst limit: move on only if someone else is waiting.
            if (pick_other_s[IDX_W]) begin
              gnt_r <= GNT_ONE << pick_other_s[IDX_W-1:0];
              ptr_r <= pick_other_s[IDX_W-1:0];
              cnt_r <= '0;
            end else begin
              cnt_r <= '0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= '0;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read return: flag the owner of a read beat for one cycle and remember the
  // returned byte so o_rdata holds it afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_r     <= '0;
      rdata_hold_r <= '0;
    end else begin
      rvalid_r <= (beat_s && !own_wr_s) ? gnt_r : '0;
      if (|rvalid_r) begin
        rdata_hold_r <= i_dram_rdata;
      end
    end
  end

  // The DRAM delivers its data during the cycle after the strobe, so that
  // cycle passes it straight through; the held copy covers every other cycle.
  always_comb begin
    if (|rvalid_r) begin
      o_rdata = i_dram_rdata;
    end else begin
      o_rdata = rdata_hold_r;
    end
  end

  assign o_gnt    = gnt_r;
  assign o_rvalid = rvalid_r;
  assign o_busy   = busy_r;

endmodule

// File: tb/tb_dram_port_arbiter.sv
`timescale 1ns/1ps
module tb_dram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, wr;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            dram_en, dram_wr, busy;
  logic [AW-1:0]   dram_addr;
  logic [DW-1:0]   dram_wdata, dram_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  dram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wr(wr), .i_addr(addr),
    .i_wdata(wdata), .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
    .o_dram_en(dram_en), .o_dram_wr(dram_wr), .o_dram_addr(dram_addr),
    .o_dram_wdata(dram_wdata), .i_dram_rdata(dram_rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    logic [15:0] v;
    v = a[15:0];
    return v[7:0] ^ v[15:8] ^ 8'h58;
  endfunction

  // DRAM stub: synchronous single port, read data valid the cycle after.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (dram_en) begin
      if (dram_wr) mem[dram_addr] <= dram_wdata;
      else         dram_rdata     <= mem[dram_addr];
    end
  end

  // ---------------- reference model (integer owner / pointer / count) -------
  int         m_owner, m_ptr, m_cnt, m_rv;
  logic [7:0] m_rdata;
  logic [7:0] m_mem [0:65535];
  int         n_owner, n_ptr, n_cnt, n_rv;
  logic [7:0] n_rdata;
  int         rd_beats;

  logic [N-1:0]  a_gnt, a_rv;
  logic [7:0]    a_rdata, a_wdata;
  logic [15:0]   a_addr;
  logic          a_en, a_wr, a_busy;

  function automatic int find_winner(input logic [N-1:0] r, input int start, input int excl);
    int c;
    for (int i = 1; i <= N; i++) begin
      c = (start + i) % N;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = N - 1; m_cnt = 0; m_rv = -1; m_rdata = 8'h00;
  endtask

  task automatic check_now();
    logic [N-1:0] e_gnt, e_rv;
    logic [15:0]  e_addr;
    logic [7:0]   e_wdata;
    logic         beat, e_wr;
    logic [42:0]  exp_v, act_v;
    int           w;
    e_gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    beat    = (m_owner >= 0) && req[m_owner];
    e_wr    = beat && wr[m_owner];
    e_addr  = (m_owner >= 0) ? addr[m_owner*AW +: AW] : 16'h0000;
    e_wdata = (m_owner >= 0) ? wdata[m_owner*DW +: DW] : 8'h00;
    e_rv    = (m_rv >= 0) ? (4'b0001 << m_rv) : 4'b0000;
    exp_v = {e_gnt, e_rv, m_rdata, beat, e_wr, e_addr, e_wdata, (m_owner >= 0)};
    a_gnt = gnt; a_rv = rvalid; a_rdata = rdata; a_en = dram_en; a_wr = dram_wr;
    a_addr = dram_addr; a_wdata = dram_wdata; a_busy = busy;
    act_v = {a_gnt, a_rv, a_rdata, a_en, a_wr, a_addr, a_wdata, a_busy};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL model cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
    end
    // next state
    n_rv = -1; n_rdata = m_rdata;
    n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt;
    if (beat && !e_wr) begin
      n_rv = m_owner; n_rdata = m_mem[e_addr]; rd_beats++;
    end
    if (beat && e_wr) m_mem[e_addr] = e_wdata;
    if (m_owner < 0 || !req[m_owner]) begin
      w = find_winner(req, m_ptr, -1);
      if (w >= 0) begin n_owner = w; n_ptr = w; n_cnt = 0; end
      else        begin n_owner = -1; n_cnt = 0; end
    end else if (m_cnt == MB - 1) begin
      w = find_winner(req, m_ptr, m_owner);
      if (w >= 0) begin n_owner = w; n_ptr = w; end
      n_cnt = 0;
    end else begin
      n_cnt = m_cnt + 1;
    end
  endtask

  task automatic advance();
    @(posedge clk); #1;
    m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt; m_rv = n_rv; m_rdata = n_rdata;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_now();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; wr = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    logic [3:0]  req, wr;
    logic [15:0] a2, a3;
    logic [7:0]  d3;
    logic [3:0]  e_gnt;
    logic        e_en, e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic [3:0]  e_rv;
    logic [7:0]  e_rdata;
  } vec_t;
  vec_t tv [9];

  initial begin
    int           rv_pulses, gaps, cnt0;
    logic [3:0]   drop, prev_g, first_other;
    logic [3:0]   order [$];
    logic [3:0]   exp_order [5];

    tv[0] = '{4'b0100, 4'b0000, 16'h0024, 16'h0000, 8'h00, 4'b0000, 1'b0, 1'b0, 16'h0000, 8'h00, 4'b0000, 8'h00};
    tv[1] = '{4'b0100, 4'b0000, 16'h0024, 16'h0000, 8'h00, 4'b0100, 1'b1, 1'b0, 16'h0024, 8'h00, 4'b0000, 8'h00};
    tv[2] = '{4'b0000, 4'b0000, 16'h0024, 16'h0000, 8'h00, 4'b0100, 1'b0, 1'b0, 16'h0024, 8'h00, 4'b0100, 8'h7C};
    tv[3] = '{4'b0000, 4'b0000, 16'h0024, 16'h0000, 8'h00, 4'b0000, 1'b0, 1'b0, 16'h0000, 8'h00, 4'b0000, 8'h7C};
    tv[4] = '{4'b1000, 4'b1000, 16'h0024, 16'h0026, 8'hC2, 4'b0000, 1'b0, 1'b0, 16'h0000, 8'h00, 4'b0000, 8'h7C};
    tv[5] = '{4'b1000, 4'b1000, 16'h0024, 16'h0026, 8'hC2, 4'b1000, 1'b1, 1'b1, 16'h0026, 8'hC2, 4'b0000, 8'h7C};
    tv[6] = '{4'b1000, 4'b0000, 16'h0024, 16'h0026, 8'hC2, 4'b1000, 1'b1, 1'b0, 16'h0026, 8'hC2, 4'b0000, 8'h7C};
    tv[7] = '{4'b0000, 4'b0000, 16'h0024, 16'h0026, 8'hC2, 4'b1000, 1'b0, 1'b0, 16'h0026, 8'hC2, 4'b1000, 8'hC2};
    tv[8] = '{4'b0000, 4'b0000, 16'h0024, 16'h0026, 8'hC2, 4'b0000, 1'b0, 1'b0, 16'h0000, 8'h00, 4'b0000, 8'hC2};
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

    for (int a = 0; a < 65536; a++) begin
      mem[a] = init_val(a); m_mem[a] = init_val(a);
    end
    rd_beats = 0;

    // Table: single read by core 2, then write + read-back by core 3.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req = tv[i].req; wr = tv[i].wr;
      addr = {tv[i].a3, tv[i].a2, 16'h0000, 16'h0000};
      wdata = {tv[i].d3, 24'h000000};
      tick();
      chk($sformatf("vec%0d", i),
          {4'h0, a_gnt, a_en, a_wr, a_busy, 1'b0, a_addr[11:0], a_wdata},
          {4'h0, tv[i].e_gnt, tv[i].e_en, tv[i].e_wr, |tv[i].e_gnt, 1'b0, tv[i].e_addr[11:0], tv[i].e_wdata});
      chk($sformatf("vec%0d_rd", i), {24'h0, a_rv, 4'h0} | {24'h0, 8'h00}, {24'h0, tv[i].e_rv, 4'h0});
      chk($sformatf("vec%0d_rdata", i), {24'h0, a_rdata}, {24'h0, tv[i].e_rdata});
    end

    // Round robin: all cores read, each releasing after one beat.
    do_reset();
    addr = {16'h0033, 16'h0022, 16'h0011, 16'h0000};
    drop = '0; prev_g = '0; gaps = 0; rv_pulses = 0; rd_beats = 0;
    for (int c = 0; c < 12; c++) begin
      req = 4'b1111 & ~drop;
      tick();
      if (a_gnt != prev_g && a_gnt != 4'b0000 && order.size() < 5) order.push_back(a_gnt);
      if (order.size() > 0 && order.size() < 5 && a_gnt == 4'b0000) gaps++;
      rv_pulses += $countones(a_rv);
      drop = a_gnt & req;
      prev_g = a_gnt;
    end
    req = '0;
    repeat (3) begin tick(); rv_pulses += $countones(a_rv); end
    chk("rr_count", order.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < order.size()) chk($sformatf("rr_order%0d", i), {28'h0, order[i]}, {28'h0, exp_order[i]});
    chk("rr_gaps", gaps, 0);
    chk("rr_rvalid", rv_pulses, rd_beats);

    // Burst limit with core 1 waiting.
    do_reset();
    req = 4'b0011; cnt0 = 0; first_other = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (a_gnt == 4'b0001) cnt0++;
      else if (cnt0 > 0) begin first_other = a_gnt; break; end
    end
    chk("burst_beats", cnt0, MB);
    chk("burst_next", {28'h0, first_other}, 32'h2);

    // No competitor: core 0 keeps the grant past the limit.
    do_reset();
    req = 4'b0001; cnt0 = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (a_gnt == 4'b0001) cnt0++;
    end
    chk("burst_alone", cnt0, 39);

    // Reset pulse during core 1's second read beat (previous read in flight).
    do_reset();
    req = 4'b0010; addr = {16'h0, 16'h0, 16'h0100, 16'h0};
    tick(); tick();
    @(negedge clk); #1;
    chk("pre_rst_rv", {28'h0, rvalid}, 32'h2);
    rst_n = 1'b0;
    #0.5;
    chk("rst_async", {20'h0, gnt, rvalid, dram_en, busy, 2'b00},
        {20'h0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00});
    chk("rst_rdata", {24'h0, rdata}, 32'h0);
    #0.5;
    rst_n = 1'b1;
    model_reset();
    req = 4'b1111;
    check_now();
    advance();
    tick();
    chk("rst_first_gnt", {28'h0, a_gnt}, 32'h1);
    chk("rst_no_rv", {28'h0, a_rv}, 32'h0);

    // Isolation: other cores' buses toggle while core 1 writes.
    do_reset();
    req = 4'b0010; wr = 4'b0010;
    addr[1*AW +: AW] = 16'h1234; wdata[1*DW +: DW] = 8'h5A;
    tick();
    for (int c = 0; c < 20; c++) begin
      addr[0*AW +: AW] = 16'($urandom); addr[2*AW +: AW] = 16'($urandom);
      addr[3*AW +: AW] = 16'($urandom);
      wdata[0*DW +: DW] = 8'($urandom); wdata[2*DW +: DW] = 8'($urandom);
      wdata[3*DW +: DW] = 8'($urandom);
      tick();
      chk("iso", {a_addr, a_wdata, 8'h00}, {16'h1234, 8'h5A, 8'h00});
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) req[k] = ~req[k];
        wr[k] = 1'($urandom);
        addr[k*AW +: AW] = 16'($urandom_range(0, 31));
        wdata[k*DW +: DW] = 8'($urandom);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
